// File: rtl/regfile_dump_reader.sv
// Register-file readback initiator: walks an address range through one read port and
// streams {addr, data} snapshots over valid/ready with a running XOR checksum.
module regfile_dump_reader #(
   parameter int unsigned ADDR_W = 5,
   parameter int unsigned DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [ADDR_W-1:0] first_reg,
   input  logic [ADDR_W-1:0] last_reg,
   output logic [ADDR_W-1:0] rd_addr,
   input  logic [DATA_W-1:0] rd_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ADDR_W-1:0] out_addr,
   output logic [DATA_W-1:0] out_data,
   output logic              out_last,
   output logic              busy,
   output logic              done,
   output logic              range_err,
   output logic [DATA_W-1:0] checksum
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_FETCH,
      S_SEND,
      S_DONE
   } state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] cur_q, cur_d;
   logic [ADDR_W-1:0] end_q, end_d;
   logic [ADDR_W-1:0] out_addr_q, out_addr_d;
   logic [DATA_W-1:0] out_data_q, out_data_d;
   logic              out_valid_q, out_valid_d;
   logic              out_last_q, out_last_d;
   logic              range_err_q, range_err_d;
   logic [DATA_W-1:0] checksum_q, checksum_d;

   always_comb begin
      state_d     = state_q;
      cur_d       = cur_q;
      end_d       = end_q;
      out_addr_d  = out_addr_q;
      out_data_d  = out_data_q;
      out_valid_d = out_valid_q;
      out_last_d  = out_last_q;
      range_err_d = 1'b0;
      checksum_d  = checksum_q;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               if (first_reg <= last_reg) begin
                  cur_d      = first_reg;
                  end_d      = last_reg;
                  checksum_d = '0;
                  state_d    = S_FETCH;
               end else begin
                  range_err_d = 1'b1;
               end
            end
         end
         S_FETCH: begin
            out_data_d  = rd_data;
            out_addr_d  = cur_q;
            out_last_d  = (cur_q == end_q);
            out_valid_d = 1'b1;
            state_d     = S_SEND;
         end
         S_SEND: begin
            if (out_ready) begin
               checksum_d  = checksum_q ^ out_data_q;
               out_valid_d = 1'b0;
               // Compare before increment so last_reg at the top of the range never wraps cur.
               if (cur_q == end_q) begin
                  state_d = S_DONE;
               end else begin
                  cur_d   = cur_q + 1'b1;
                  state_d = S_FETCH;
               end
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         cur_q       <= '0;
         end_q       <= '0;
         out_addr_q  <= '0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         range_err_q <= 1'b0;
         checksum_q  <= '0;
      end else begin
         state_q     <= state_d;
         cur_q       <= cur_d;
         end_q       <= end_d;
         out_addr_q  <= out_addr_d;
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
         out_last_q  <= out_last_d;
         range_err_q <= range_err_d;
         checksum_q  <= checksum_d;
      end
   end

   assign rd_addr   = (state_q == S_FETCH) ? cur_q : '0;
   assign out_valid = out_valid_q;
   assign out_addr  = out_addr_q;
   assign out_data  = out_data_q;
   assign out_last  = out_last_q;
   assign busy      = (state_q == S_FETCH) || (state_q == S_SEND);
   assign done      = (state_q == S_DONE);
   assign range_err = range_err_q;
   assign checksum  = checksum_q;

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Bench for regfile_dump_reader: table of dump scenarios plus hand-written range-error,
// reset-abort and randomized dumps, all checked against a register-array reference model.
module tb_regfile_dump_reader;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [4:0]  first_reg;
   logic [4:0]  last_reg;
   logic [4:0]  rd_addr;
   logic [31:0] rd_data;
   logic        out_valid;
   logic        out_ready;
   logic [4:0]  out_addr;
   logic [31:0] out_data;
   logic        out_last;
   logic        busy;
   logic        done;
   logic        range_err;
   logic [31:0] checksum;

   logic [31:0] regs [32];
   assign rd_data = regs[rd_addr];

   always #5 clk = ~clk;

   regfile_dump_reader #(
      .ADDR_W(5),
      .DATA_W(32)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .first_reg(first_reg),
      .last_reg (last_reg),
      .rd_addr  (rd_addr),
      .rd_data  (rd_data),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_addr (out_addr),
      .out_data (out_data),
      .out_last (out_last),
      .busy     (busy),
      .done     (done),
      .range_err(range_err),
      .checksum (checksum)
   );

   typedef struct {
      int first;
      int last;
      int stall;      // cycles out_ready held low on every word
      int wr_addr;    // register rewritten while its word is stalled (-1: none)
      int poke_word;  // word index at which a stray start is issued (-1: none)
      int exp_words;
   } vec_t;

   int          checks = 0;
   int          errors = 0;
   logic [31:0] last_ck = '0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic run_dump(input vec_t v);
      logic [31:0] qa [$];
      logic [31:0] qd [$];
      logic [31:0] ck;
      logic [4:0]  ha;
      logic [31:0] hd;
      logic        hl;
      int          n, w, guard, tc;
      ck = '0;
      for (int i = v.first; i <= v.last; i++) begin
         qa.push_back(32'(i));
         qd.push_back(regs[i]);
         ck ^= regs[i];
      end
      first_reg = 5'(v.first);
      last_reg  = 5'(v.last);
      start     = 1'b1;
      out_ready = (v.stall == 0);
      @(negedge clk);
      start = 1'b0;
      tc = 1; n = 0; w = 0; guard = 0;
      chk("busy_after_start", 32'(busy), 32'd1);
      while (!done && guard < 400) begin
         if (out_valid) begin
            chk("word_latency", 32'(w), 32'd1);
            if (n < qa.size()) begin
               chk("out_addr", 32'(out_addr), qa[n]);
               chk("out_data", out_data, qd[n]);
               chk("out_last", 32'(out_last), 32'(n == qa.size() - 1));
            end else begin
               chk("extra_word", 32'(n), 32'(qa.size()));
            end
            if (n == v.poke_word) begin
               start = 1'b1; first_reg = 5'd20; last_reg = 5'd25;
            end
            if (v.stall > 0) begin
               ha = out_addr; hd = out_data; hl = out_last;
               repeat (v.stall) begin
                  if (v.wr_addr == int'(out_addr)) regs[v.wr_addr] = ~regs[v.wr_addr];
                  @(negedge clk);
                  tc++;
                  start = 1'b0;
                  chk("stall_valid", 32'(out_valid), 32'd1);
                  chk("stall_addr", 32'(out_addr), 32'(ha));
                  chk("stall_data", out_data, hd);
                  chk("stall_last", 32'(out_last), 32'(hl));
               end
               out_ready = 1'b1;
            end
            @(negedge clk);
            tc++;
            start = 1'b0;
            if (v.stall > 0) out_ready = 1'b0;
            n++;
            w = 0;
         end else begin
            @(negedge clk);
            tc++;
            w++;
            guard++;
         end
      end
      chk("done_seen", 32'(done), 32'd1);
      chk("word_count", 32'(n), 32'(v.exp_words));
      chk("done_cycle", 32'(tc), 32'(v.exp_words * (2 + v.stall) + 1));
      chk("checksum", checksum, ck);
      chk("busy_in_done", 32'(busy), 32'd0);
      @(negedge clk);
      chk("done_pulse_end", 32'(done), 32'd0);
      chk("checksum_hold", checksum, ck);
      last_ck = ck;
      out_ready = 1'b1;
   endtask

   vec_t tbl [7];
   vec_t rv;

   initial begin
      tbl[0] = '{first:0,  last:31, stall:0, wr_addr:-1, poke_word:-1, exp_words:32};
      tbl[1] = '{first:4,  last:6,  stall:5, wr_addr:5,  poke_word:-1, exp_words:3};
      tbl[2] = '{first:17, last:17, stall:0, wr_addr:-1, poke_word:-1, exp_words:1};
      tbl[3] = '{first:0,  last:3,  stall:0, wr_addr:-1, poke_word:1,  exp_words:4};
      tbl[4] = '{first:31, last:31, stall:1, wr_addr:-1, poke_word:-1, exp_words:1};
      tbl[5] = '{first:28, last:31, stall:2, wr_addr:-1, poke_word:0,  exp_words:4};
      tbl[6] = '{first:0,  last:0,  stall:0, wr_addr:-1, poke_word:-1, exp_words:1};

      rst_n = 1'b0; start = 1'b0; first_reg = '0; last_reg = '0; out_ready = 1'b1;
      for (int i = 0; i < 32; i++) regs[i] = 32'(i * 3);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      chk("rst_rd_addr", 32'(rd_addr), 32'd0);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_addr", 32'(out_addr), 32'd0);
      chk("rst_out_data", out_data, 32'd0);
      chk("rst_out_last", 32'(out_last), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_range_err", 32'(range_err), 32'd0);
      chk("rst_checksum", checksum, 32'd0);

      for (int t = 0; t < 7; t++) begin
         if (t == 1) regs[17] = 32'hDEADBEEF;
         run_dump(tbl[t]);
      end

      // Rejected range: pulse next cycle, nothing else moves.
      first_reg = 5'd9; last_reg = 5'd3; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("rerr_pulse", 32'(range_err), 32'd1);
      chk("rerr_busy", 32'(busy), 32'd0);
      chk("rerr_valid", 32'(out_valid), 32'd0);
      @(negedge clk);
      chk("rerr_pulse_end", 32'(range_err), 32'd0);
      chk("rerr_no_done", 32'(done), 32'd0);
      chk("rerr_busy2", 32'(busy), 32'd0);
      chk("rerr_checksum", checksum, last_ck);

      // Reset while word 10 is stalled in SEND.
      for (int i = 1; i < 32; i++) regs[i] = $urandom;
      first_reg = 5'd8; last_reg = 5'd15; start = 1'b1; out_ready = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int g = 0; g < 40; g++) begin
         if (out_valid && out_addr == 5'd10) break;
         @(negedge clk);
      end
      out_ready = 1'b0;
      chk("abort_at_reg10", 32'(out_addr), 32'd10);
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      chk("abort_valid", 32'(out_valid), 32'd0);
      chk("abort_addr", 32'(out_addr), 32'd0);
      chk("abort_data", out_data, 32'd0);
      chk("abort_last", 32'(out_last), 32'd0);
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_done", 32'(done), 32'd0);
      chk("abort_checksum", checksum, 32'd0);
      chk("abort_rd_addr", 32'(rd_addr), 32'd0);
      out_ready = 1'b1;
      run_dump('{first:8, last:15, stall:0, wr_addr:-1, poke_word:-1, exp_words:8});

      for (int r = 0; r < 8; r++) begin
         for (int i = 0; i < 32; i++) regs[i] = $urandom;
         rv.first     = int'($urandom_range(31, 0));
         rv.last      = int'($urandom_range(31, rv.first));
         rv.stall     = int'($urandom_range(2, 0));
         rv.wr_addr   = rv.first;
         rv.poke_word = -1;
         rv.exp_words = rv.last - rv.first + 1;
         run_dump(rv);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
